// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams 32-bit big-endian message words and emits
// padded 512-bit blocks (data, 0x80 marker, zero fill, 64-bit bit length).
module sha256_msg_padder #(
    parameter int LEN_BITS = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [2:0]          in_nbytes,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_first,
    output logic                out_blk_end,
    output logic                out_msg_end,
    output logic [LEN_BITS-1:0] len_o,
    output logic                len_load
);

    typedef enum logic [2:0] {DATA, MARK, ZERO, LEN_HI, LEN_LO} state_t;

    state_t                state_q, state_d;
    logic [3:0]            widx;
    logic [3:0]            nidx;
    logic [LEN_BITS-1:0]   bitcnt;
    logic [LEN_BITS-1:0]   add_bits;
    logic [63:0]           len64;
    logic [2:0]            nb_last;
    logic [2:0]            add_bytes;
    logic                  slot;
    logic                  ld;
    logic [31:0]           ld_data;
    logic                  ld_msg_end;
    logic                  acc;
    logic                  done;

    // Keep bytes below nb, place the 0x80 marker at byte nb, zero the rest.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [1:0] nb);
        logic [31:0] w;
        case (nb)
            2'd0:    w = 32'h8000_0000;
            2'd1:    w = {d[31:24], 24'h80_0000};
            2'd2:    w = {d[31:16], 16'h8000};
            default: w = {d[31:8], 8'h80};
        endcase
        return w;
    endfunction

    assign slot      = !out_valid || out_ready;
    // Index of the word being loaded into the output stage this cycle.
    assign nidx      = widx + {3'b000, out_valid & out_ready};
    assign nb_last   = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign add_bytes = in_last ? nb_last : 3'd4;
    assign add_bits  = LEN_BITS'({add_bytes, 3'b000});
    assign len64     = 64'(bitcnt);

    assign in_ready    = RST && (state_q == DATA) && slot;
    assign out_first   = out_valid && (widx == 4'd0);
    assign out_blk_end = out_valid && (widx == 4'd15);

    always_comb begin
        state_d    = state_q;
        ld         = 1'b0;
        ld_data    = '0;
        ld_msg_end = 1'b0;
        acc        = 1'b0;
        done       = 1'b0;
        case (state_q)
            DATA: begin
                if (in_valid && slot) begin
                    acc     = 1'b1;
                    ld      = 1'b1;
                    ld_data = in_data;
                    if (in_last) begin
                        if (nb_last == 3'd4) begin
                            state_d = MARK;
                        end else begin
                            ld_data = pad_word(in_data, nb_last[1:0]);
                            state_d = (nidx == 4'd13) ? LEN_HI : ZERO;
                        end
                    end
                end
            end
            MARK: begin
                if (slot) begin
                    ld      = 1'b1;
                    ld_data = 32'h8000_0000;
                    state_d = (nidx == 4'd13) ? LEN_HI : ZERO;
                end
            end
            // Zero fill ends at index 13 so the length lands in words 14/15,
            // spilling into an extra block when the marker sat at 14 or 15.
            ZERO: begin
                if (slot) begin
                    ld      = 1'b1;
                    state_d = (nidx == 4'd13) ? LEN_HI : ZERO;
                end
            end
            LEN_HI: begin
                if (slot) begin
                    ld      = 1'b1;
                    ld_data = len64[63:32];
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (out_valid && out_msg_end) begin
                    if (out_ready) begin
                        done    = 1'b1;
                        state_d = DATA;
                    end
                end else if (slot) begin
                    ld         = 1'b1;
                    ld_data    = len64[31:0];
                    ld_msg_end = 1'b1;
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= DATA;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            widx        <= '0;
            bitcnt      <= '0;
            len_o       <= '0;
            len_load    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_msg_end <= 1'b0;
        end else begin
            len_load <= acc && in_last;
            if (acc && in_last) begin
                len_o <= bitcnt + add_bits;
            end
            if (done) begin
                bitcnt <= '0;
            end else if (acc) begin
                bitcnt <= bitcnt + add_bits;
            end
            if (out_valid && out_ready) begin
                widx <= widx + 4'd1;
            end
            if (slot) begin
                out_valid   <= ld;
                out_msg_end <= ld && ld_msg_end;
                if (ld) begin
                    out_data <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level padding model feeding a scoreboard,
// plus directed messages, backpressure and mid-message reset.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_blk_end;
    logic        out_msg_end;
    logic [63:0] len_o;
    logic        len_load;

    sha256_msg_padder #(.LEN_BITS(64)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_nbytes(in_nbytes),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_blk_end(out_blk_end), .out_msg_end(out_msg_end),
        .len_o(len_o), .len_load(len_load)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        be;
        logic        me;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_cur;
    logic [63:0] len_q[$];
    logic [7:0]  msg[$];
    logic [31:0] mw[$];
    int          errors = 0;
    int          checks = 0;
    bit          check_en = 1'b0;
    bit          abort = 1'b0;
    bit          thr = 1'b0;
    int          tot_out = 0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Padding from first principles: append 0x80, zero bytes until length is
    // 56 mod 64, then the 64-bit big-endian bit count; pack 4 bytes per word.
    task automatic pad_model();
        logic [7:0]  q[$];
        logic [63:0] nbits;
        q = msg;
        nbits = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) q.push_back(nbits[8*i +: 8]);
        mw.delete();
        for (int k = 0; k < q.size() / 4; k++)
            mw.push_back({q[4*k], q[4*k+1], q[4*k+2], q[4*k+3]});
    endtask

    task automatic expect_msg();
        exp_t e;
        pad_model();
        for (int k = 0; k < mw.size(); k++) begin
            e.d  = mw[k];
            e.f  = ((k % 16) == 0);
            e.be = ((k % 16) == 15);
            e.me = (k == mw.size() - 1);
            exp_q.push_back(e);
        end
        len_q.push_back(64'(msg.size()) * 64'd8);
    endtask

    task automatic make_msg(input int n, input int seed);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(i * 37 + seed));
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        bit got;
        int cnt;
        got = 1'b0;
        cnt = 0;
        in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
        while (!got && !abort && cnt < 500) begin
            @(negedge CLK);
            got = in_ready;
            @(posedge CLK);
            #1;
            cnt++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!got && !abort) begin
            checks++;
            errors++;
            $display("FAIL in_timeout: word %h not accepted after %0d cycles", d, cnt);
        end
    endtask

    // Bytes past the message end carry 0xA5 so the padder must mask them.
    task automatic send_msg();
        int          n;
        int          nw;
        logic [31:0] w;
        logic [2:0]  nb;
        n = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        expect_msg();
        for (int k = 0; k < nw && !abort; k++) begin
            for (int b = 0; b < 4; b++)
                w[31-8*b -: 8] = (4*k + b < n) ? msg[4*k + b] : 8'hA5;
            nb = (k == nw - 1) ? 3'(n - 4*k) : 3'd4;
            send_word(w, (k == nw - 1), nb);
        end
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && cnt < 2000) begin
            @(posedge CLK);
            cnt++;
        end
        chk("drain_words_left", 64'(exp_q.size()), 64'd0);
        chk("drain_len_left", 64'(len_q.size()), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            if (out_valid && out_ready) begin
                tot_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h required none", out_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e_cur.d));
                    chk("out_flags", 64'({out_first, out_blk_end, out_msg_end}),
                        64'({e_cur.f, e_cur.be, e_cur.me}));
                end
            end
            if (len_load) begin
                if (len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_len_load: got len_o %h required no pulse", len_o);
                end else begin
                    chk("len_o", len_o, len_q.pop_front());
                end
            end
        end
    end

    always @(posedge CLK) begin
        cyc++;
        #1;
        if (thr) out_ready = ((cyc % 3) != 0);
    end

    task automatic chk_all_zero(input string nm);
        chk(nm, 64'({out_valid, out_first, out_blk_end, out_msg_end, len_load, in_ready, out_data}), 64'd0);
        chk({nm, "_len"}, len_o, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        logic [31:0] tmp;
        int          base;
        int          cnt;
        int          lens[8];
        lens = '{57, 60, 62, 64, 4, 1, 2, 130};

        in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0; out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset_outs");
        #2 RST = 1'b1;
        check_en = 1'b1;
        @(posedge CLK);
        #1;

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        pad_model();
        chk("model_abc_w0", 64'(mw[0]), 64'h6162_6380);
        chk("model_abc_w15", 64'(mw[15]), 64'h18);
        chk("model_abc_n", 64'(mw.size()), 64'd16);
        send_msg();
        wait_drain();

        // empty message
        msg.delete();
        pad_model();
        chk("model_empty_w0", 64'(mw[0]), 64'h8000_0000);
        chk("model_empty_w15", 64'(mw[15]), 64'h0);
        send_msg();
        wait_drain();

        // 56 bytes: marker at word 14 forces a second block
        make_msg(56, 1);
        pad_model();
        chk("model_56_n", 64'(mw.size()), 64'd32);
        chk("model_56_w14", 64'(mw[14]), 64'h8000_0000);
        chk("model_56_w31", 64'(mw[31]), 64'h1C0);
        send_msg();
        wait_drain();

        // 55 bytes: marker shares word 13 with data
        make_msg(55, 2);
        pad_model();
        chk("model_55_n", 64'(mw.size()), 64'd16);
        tmp = mw[13];
        chk("model_55_w13_b3", 64'(tmp[7:0]), 64'h80);
        chk("model_55_w15", 64'(mw[15]), 64'h1B8);
        send_msg();
        wait_drain();

        // boundary lengths, throttled sink, back-to-back messages
        thr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            make_msg(lens[i], 10 + i);
            send_msg();
        end
        wait_drain();
        thr = 1'b0;
        #1 out_ready = 1'b1;
        @(posedge CLK);
        #1;

        // backpressure: five stalled cycles mid-block
        make_msg(40, 3);
        fork
            send_msg();
            begin
                repeat (6) @(posedge CLK);
                #1 out_ready = 1'b0;
                @(negedge CLK);
                held = out_data;
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready0", 64'(in_ready), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge CLK);
                    chk("stall_data", 64'(out_data), 64'(held));
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge CLK);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset after seven words of a 20-word message
        make_msg(80, 4);
        base = tot_out;
        fork
            send_msg();
            begin
                cnt = 0;
                while (tot_out < base + 7 && cnt < 500) begin
                    @(posedge CLK);
                    #2;
                    cnt++;
                end
                chk("widx7_reached", 64'(tot_out - base), 64'd7);
                abort = 1'b1;
                check_en = 1'b0;
                RST = 1'b0;
                #1;
                chk_all_zero("mid_reset_outs");
                @(negedge CLK);
                chk_all_zero("mid_reset_hold");
                exp_q.delete();
                len_q.delete();
                repeat (3) @(posedge CLK);
                #2 RST = 1'b1;
                abort = 1'b0;
                check_en = 1'b1;
            end
        join
        @(posedge CLK);
        #1;

        // fresh message after reset: block starts at word 0, count restarted
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg();
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
